// File: rtl/dram_arb_pkg.sv
// Shared types and constants for the DRAM arbiter: FSM state encoding,
// default bus widths and the width of a core index.
package dram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 32;
  localparam int CORE_ID_W  = 3;

endpackage

// File: rtl/rr_pick.sv
// Combinational requester picker: first set bit at/after ptr (wrapping), or a
// lowest-index-wins priority encoder when DRAM_ARB_FIXED_PRIO_EN is defined.
module rr_pick
  import dram_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
`ifndef DRAM_ARB_FIXED_PRIO_EN
  input  logic [CORE_ID_W-1:0] ptr,
`endif
  output logic [CORE_ID_W-1:0] idx,
  output logic                 found
);

`ifdef DRAM_ARB_FIXED_PRIO_EN

  always_comb begin
    idx   = '0;
    found = 1'b0;
    // Scan downwards so the lowest set index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = CORE_ID_W'(i);
        found = 1'b1;
      end
    end
  end

`else

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] rot;
  int             sum;

  assign dbl = {req, req};
  assign rot = dbl >> ptr;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    sum   = 0;
    // rot[k] corresponds to core (ptr + k) mod N.
    for (int k = 0; k < N; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        sum   = int'(ptr) + k;
        if (sum >= N) sum = sum - N;
        idx   = CORE_ID_W'(sum);
      end
    end
  end

`endif

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one DRAM among NUM_CORES requesters: IDLE->ACCESS->RESP,
// ack two cycles after the request edge. Define DRAM_ARB_FIXED_PRIO_EN for fixed priority.
module dram_arbiter
  import dram_arb_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CORES-1:0]        core_req,
  input  logic [NUM_CORES-1:0]        core_we,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
  input  logic [NUM_CORES-1:0]        core_end,
  output logic [NUM_CORES-1:0]        core_ack,
  output logic [DATA_W-1:0]           core_rdata,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic [CORE_ID_W-1:0]        grant_id,
  output logic                        busy,
  output logic                        all_done
);

  state_t                 state;
  state_t                 state_nxt;
  logic [CORE_ID_W-1:0]   pick_idx;
  logic                   pick_found;
  logic                   sel_we;
  logic [ADDR_W-1:0]      sel_addr;
  logic [DATA_W-1:0]      sel_wdata;
  logic [CORE_ID_W-1:0]   owner_id;
  logic                   owner_we;
  logic [ADDR_W-1:0]      owner_addr;
  logic [DATA_W-1:0]      owner_wdata;

`ifdef DRAM_ARB_FIXED_PRIO_EN

  rr_pick #(.N(NUM_CORES)) u_pick (
    .req   (core_req),
    .idx   (pick_idx),
    .found (pick_found)
  );

`else

  logic [CORE_ID_W-1:0] rr_ptr;
  logic [CORE_ID_W-1:0] ptr_nxt;

  rr_pick #(.N(NUM_CORES)) u_pick (
    .req   (core_req),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // The core just served drops to lowest priority for the next round.
  assign ptr_nxt = (owner_id == CORE_ID_W'(NUM_CORES - 1)) ? '0 : owner_id + CORE_ID_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (state == RESP) begin
      rr_ptr <= ptr_nxt;
    end
  end

`endif

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (pick_idx == CORE_ID_W'(i)) begin
        sel_we    = core_we[i];
        sel_addr  = core_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = core_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Owner copies are frozen for the whole access; later input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_id    <= '0;
      owner_we    <= 1'b0;
      owner_addr  <= '0;
      owner_wdata <= '0;
    end else if (state == IDLE && pick_found) begin
      owner_id    <= pick_idx;
      owner_we    <= sel_we;
      owner_addr  <= sel_addr;
      owner_wdata <= sel_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    core_ack   = '0;
    core_rdata = '0;
    case (state)
      IDLE: begin
        if (pick_found) state_nxt = ACCESS;
      end
      ACCESS: begin
        mem_en    = 1'b1;
        mem_we    = owner_we;
        mem_addr  = owner_addr;
        mem_wdata = owner_wdata;
        state_nxt = RESP;
      end
      RESP: begin
        for (int i = 0; i < NUM_CORES; i++) begin
          core_ack[i] = (owner_id == CORE_ID_W'(i));
        end
        core_rdata = owner_we ? '0 : mem_rdata;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      all_done <= 1'b0;
    end else begin
      all_done <= &core_end;
    end
  end

  assign grant_id = owner_id;
  assign busy     = (state != IDLE);

endmodule
